// File: rtl/branch_select_arb_pkg.sv
// Shared types for the branch select arbiter: the branch provider record,
// the flush-window FSM state encoding and the default sequence number width.
package branch_select_arb_pkg;

  localparam int unsigned SQN_W_DEF = 6;
  localparam int unsigned PC_W      = 32;

  typedef struct packed {
    logic                 taken;
    logic [PC_W-1:0]      dstPC;
    logic [SQN_W_DEF-1:0] sqN;
    logic [SQN_W_DEF-1:0] loadSqN;
    logic [SQN_W_DEF-1:0] storeSqN;
    logic                 flush;
  } BranchProv;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_FLUSH,
    MS_DRAIN
  } MispredState_t;

endpackage

// File: rtl/branch_select_arb_age_min_tree.sv
// age_min_tree: balanced comparison tree returning the index of the valid
// entry with the smallest age. Ties resolve to the lower index.
module age_min_tree #(
  parameter int unsigned N     = 4,
  parameter int unsigned AGE_W = 6,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [AGE_W-1:0] age [N],
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  localparam int unsigned LVLS   = (N > 1) ? $clog2(N) : 0;
  localparam int unsigned LEAVES = 1 << LVLS;

  // Level 0 holds the (padded) leaves; each higher level halves the node count.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int unsigned W = LEAVES >> l;
    for (genvar j = 0; j < W; j++) begin : g_node
      logic             v;
      logic [AGE_W-1:0] a;
      logic [IDX_W-1:0] ix;
      if (l == 0) begin : g_leaf
        if (j < N) begin : g_used
          assign v  = valid[j];
          assign a  = age[j];
          assign ix = IDX_W'(j);
        end else begin : g_pad
          assign v  = 1'b0;
          assign a  = '0;
          assign ix = '0;
        end
      end else begin : g_cmp
        logic pick_r;
        // Right child wins only when strictly younger-in-age, keeping the lower index on ties.
        assign pick_r = g_lvl[l-1].g_node[2*j+1].v &&
                        (!g_lvl[l-1].g_node[2*j].v ||
                         (g_lvl[l-1].g_node[2*j+1].a < g_lvl[l-1].g_node[2*j].a));
        assign v  = g_lvl[l-1].g_node[2*j].v | g_lvl[l-1].g_node[2*j+1].v;
        assign a  = pick_r ? g_lvl[l-1].g_node[2*j+1].a  : g_lvl[l-1].g_node[2*j].a;
        assign ix = pick_r ? g_lvl[l-1].g_node[2*j+1].ix : g_lvl[l-1].g_node[2*j].ix;
      end
    end
  end

  assign win_vld = g_lvl[LVLS].g_node[0].v;
  assign win_idx = g_lvl[LVLS].g_node[0].ix;

endmodule

// File: rtl/branch_select_arb.sv
// branch_select_arb: picks the oldest taken branch (age relative to the ROB
// head), runs the IDLE/FLUSH/DRAIN flush window that suppresses younger
// redirects, and counts accepted redirects (saturating).
// Optional: BRANCH_SEL_OUT_REG_EN registers OUT_branch (one cycle latency).
module branch_select_arb
  import branch_select_arb_pkg::*;
#(
  parameter int unsigned NUM_BRANCHES = 4,
  parameter int unsigned SQN_W        = SQN_W_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  BranchProv        IN_branches [NUM_BRANCHES],
  input  logic [SQN_W-1:0] IN_ROB_curSqN,
  input  logic [SQN_W-1:0] IN_RN_nextSqN,
  output BranchProv        OUT_branch,
  output logic             OUT_mispredFlush,
  output logic [CNT_W-1:0] OUT_mispredCount
);

  localparam int unsigned IDX_W = (NUM_BRANCHES > 1) ? $clog2(NUM_BRANCHES) : 1;

  MispredState_t           state;
  logic [SQN_W-1:0]        flush_sqn;
  logic [SQN_W-1:0]        flush_age;
  logic [SQN_W-1:0]        age [NUM_BRANCHES];
  logic [NUM_BRANCHES-1:0] elig;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_vld;
  BranchProv               winner;
  logic                    flush_q;
  logic [CNT_W-1:0]        cnt_q;

  // Ages relative to the ROB head; inside an open window, anything not strictly older than the flush point is dropped.
  always_comb begin
    flush_age = flush_sqn - IN_ROB_curSqN;
    for (int unsigned i = 0; i < NUM_BRANCHES; i++) begin
      age[i]  = IN_branches[i].sqN - IN_ROB_curSqN;
      elig[i] = IN_branches[i].taken && !((state != MS_IDLE) && (age[i] >= flush_age));
    end
  end

  age_min_tree #(
    .N     (NUM_BRANCHES),
    .AGE_W (SQN_W),
    .IDX_W (IDX_W)
  ) u_tree (
    .valid   (elig),
    .age     (age),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Winner record with taken forced high.
  always_comb begin
    winner       = IN_branches[win_idx];
    winner.taken = 1'b1;
  end

`ifdef BRANCH_SEL_OUT_REG_EN
  BranchProv out_q;

  // Registered redirect, aligned with the FSM/counter update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_q <= '0;
    else      out_q <= win_vld ? winner : '0;
  end

  assign OUT_branch = out_q;
`else
  // Combinational redirect, forced to zero while reset is held.
  always_comb begin
    OUT_branch = (rst && win_vld) ? winner : '0;
  end
`endif

  // Flush-window FSM and saturating redirect counter; an accept overrides any other transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MS_IDLE;
      flush_sqn <= '0;
      flush_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (win_vld) begin
      flush_sqn <= winner.sqN;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      if (IN_ROB_curSqN != IN_RN_nextSqN) begin
        state   <= MS_FLUSH;
        flush_q <= 1'b1;
      end else begin
        state   <= MS_IDLE;
        flush_q <= 1'b0;
      end
    end else begin
      case (state)
        MS_FLUSH: if (IN_ROB_curSqN == IN_RN_nextSqN) state <= MS_DRAIN;
        MS_DRAIN: begin
          state   <= MS_IDLE;
          flush_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign OUT_mispredFlush = flush_q;
  assign OUT_mispredCount = cnt_q;

endmodule

// File: tb/tb_branch_select_arb.sv
// Scoreboard bench for branch_select_arb: expected redirects are pushed when
// inputs are applied and popped when the DUT output is due.
module tb_branch_select_arb;
  import branch_select_arb_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned SW = 6;
  localparam int unsigned CW = 16;
`ifdef BRANCH_SEL_OUT_REG_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  BranchProv     br [NB];
  logic [SW-1:0] cur, nxt;
  BranchProv     out_br;
  logic          out_fl;
  logic [CW-1:0] out_cnt;

  branch_select_arb #(
    .NUM_BRANCHES (NB),
    .SQN_W        (SW),
    .CNT_W        (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_branches      (br),
    .IN_ROB_curSqN    (cur),
    .IN_RN_nextSqN    (nxt),
    .OUT_branch       (out_br),
    .OUT_mispredFlush (out_fl),
    .OUT_mispredCount (out_cnt)
  );

  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  BranchProv     exp_q [$];
  MispredState_t m_state;
  logic [SW-1:0] m_fsqn;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference selection: linear scan, strict '<' keeps the lowest index on ties.
  function automatic int model_pick();
    int            best = -1;
    logic [SW-1:0] ba, a, fa;
    ba = '0;
    fa = m_fsqn - cur;
    for (int i = 0; i < NB; i++) begin
      if (br[i].taken) begin
        a = br[i].sqN - cur;
        if (!(m_state != MS_IDLE && a >= fa)) begin
          if (best < 0 || a < ba) begin
            best = i;
            ba   = a;
          end
        end
      end
    end
    return best;
  endfunction

  task automatic cycle();
    BranchProv e;
    int        w;
    @(negedge clk);
    check("flush", {63'd0, out_fl}, {63'd0, (m_state != MS_IDLE)});
    check("count", {48'd0, out_cnt}, {48'd0, m_cnt});
    w = model_pick();
    e = '0;
    if (w >= 0) begin
      e       = br[w];
      e.taken = 1'b1;
    end
    exp_q.push_back(e);
    if (exp_q.size() > LAT) check("branch", {12'd0, out_br}, {12'd0, exp_q.pop_front()});
    if (w >= 0) begin
      m_fsqn = br[w].sqN;
      if (m_cnt != '1) m_cnt++;
      m_state = (cur != nxt) ? MS_FLUSH : MS_IDLE;
    end else begin
      case (m_state)
        MS_FLUSH: if (cur == nxt) m_state = MS_DRAIN;
        MS_DRAIN: m_state = MS_IDLE;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_flush", {63'd0, out_fl}, 64'd0);
    check("rst_count", {48'd0, out_cnt}, 64'd0);
    check("rst_branch", {12'd0, out_br}, 64'd0);
    m_state = MS_IDLE;
    m_fsqn  = '0;
    m_cnt   = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    if (LAT > 0) exp_q.push_back('0);
  endtask

  task automatic set_br(input int i, input logic [SW-1:0] s, input logic [31:0] pc);
    br[i]          = '0;
    br[i].taken    = 1'b1;
    br[i].sqN      = s;
    br[i].dstPC    = pc;
    br[i].loadSqN  = s + 6'd1;
    br[i].storeSqN = s + 6'd2;
    br[i].flush    = s[0];
  endtask

  task automatic clear_br();
    for (int i = 0; i < NB; i++) br[i] = '0;
  endtask

  task automatic drain();
    clear_br();
    nxt = cur;
    cycle();
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    cur = '0;
    nxt = '0;
    clear_br();
    @(posedge clk);
    #1;
    do_reset();

    // Oldest of two taken branches, flush rises next cycle
    cur = 6'd5; nxt = 6'd12;
    set_br(1, 6'd9, 32'h0000_1111);
    set_br(3, 6'd7, 32'h0000_3333);
    cycle();
    check("t1_flush", {63'd0, out_fl}, 64'd1);
    check("t1_count", {48'd0, out_cnt}, 64'd1);

    // In FLUSH with flushSqN=7: equal and younger dropped, older accepted
    clear_br();
    set_br(0, 6'd7, 32'h0000_aaaa);
    set_br(2, 6'd10, 32'h0000_bbbb);
    cycle();
    check("t2_hold_count", {48'd0, out_cnt}, 64'd1);
    clear_br();
    set_br(1, 6'd6, 32'h0000_cccc);
    cycle();
    check("t2_older_count", {48'd0, out_cnt}, 64'd2);

    // Drain: DRAIN at d+1 (flush still high), flush low at d+2
    clear_br();
    nxt = cur;
    cycle();
    check("drain_d1", {63'd0, out_fl}, 64'd1);
    cycle();
    check("drain_d2", {63'd0, out_fl}, 64'd0);

    // Branch arriving during DRAIN restarts the window
    nxt = 6'd12;
    set_br(0, 6'd8, 32'h0000_0808);
    cycle();
    clear_br();
    nxt = cur;
    cycle();
    nxt = 6'd12;
    set_br(2, 6'd6, 32'h0000_0606);
    cycle();
    check("drain_reacc_flush", {63'd0, out_fl}, 64'd1);
    check("drain_reacc_count", {48'd0, out_cnt}, 64'd4);
    drain();

    // Wrap-around ages
    cur = 6'd60; nxt = 6'd8;
    set_br(0, 6'd2, 32'h0000_0002);
    set_br(2, 6'd62, 32'h0000_0062);
    cycle();
    drain();
    cur = 6'd60; nxt = 6'd31;
    set_br(1, 6'd29, 32'h0000_0029);
    set_br(3, 6'd61, 32'h0000_0061);
    cycle();
    drain();

    // Equal sqN: lowest channel's dstPC wins
    cur = 6'd10; nxt = 6'd30;
    set_br(0, 6'd20, 32'h0000_1000);
    set_br(2, 6'd20, 32'h0000_2000);
    cycle();
    drain();

    // Randomised traffic
    for (int k = 0; k < 200; k++) begin
      int unsigned win;
      cur = 6'($urandom);
      win = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      nxt = cur + 6'(win);
      for (int i = 0; i < NB; i++) begin
        br[i]          = '0;
        br[i].taken    = ($urandom_range(0, 2) == 0);
        br[i].sqN      = cur + 6'((win == 0) ? 0 : $urandom_range(0, win - 1));
        br[i].dstPC    = $urandom;
        br[i].loadSqN  = 6'($urandom);
        br[i].storeSqN = 6'($urandom);
        br[i].flush    = 1'($urandom);
      end
      cycle();
    end
    drain();

    // Reset in the middle of a FLUSH window
    cur = 6'd5; nxt = 6'd12;
    set_br(0, 6'd9, 32'h0000_9999);
    cycle();
    check("pre_rst_flush", {63'd0, out_fl}, 64'd1);
    do_reset();
    cycle();
    check("post_rst_count", {48'd0, out_cnt}, 64'd1);
    check("post_rst_flush", {63'd0, out_fl}, 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_select_arb.md
# branch_select_arb

Parametrised mispredict arbiter between the execution-unit branch providers and the frontend/ROB flush logic. Each cycle it picks the oldest taken branch among `NUM_BRANCHES` providers, judging age relative to the ROB head rather than by pairwise difference. It then runs an explicit flush-window FSM that suppresses younger redirects until the window drains. It also keeps a mispredict counter for perf monitoring.

## Interface
- `NUM_BRANCHES`, 4: number of branch provider channels.
- `SQN_W`, 6: sequence number width. The ROB window is less than 2^SQN_W.
- `CNT_W`, 16: mispredict counter width.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `IN_branches` in `BranchProv[NUM_BRANCHES]`: each entry has `taken`, `dstPC`, `sqN`, `loadSqN`, `storeSqN`, `flush`.
- `IN_ROB_curSqN` in `SQN_W`: ROB head sequence number.
- `IN_RN_nextSqN` in `SQN_W`: next sequence number the rename stage will allocate.
- `OUT_branch` out `BranchProv`: the selected redirect.
- `OUT_mispredFlush` out 1: flush window active.
- `OUT_mispredCount` out `CNT_W`: number of accepted redirects, saturating.

## Operation
- Age of a branch is `age = sqN - IN_ROB_curSqN`, computed mod 2^SQN_W and treated as unsigned. A smaller age means an older branch.
- Eligibility: a branch is eligible when `taken` is set and it is not suppressed.
  - A branch is suppressed when state ≠ IDLE and `age(sqN) >= age(flushSqN)`.
  - The equal case is suppressed, so a repeated redirect of the same sqN is dropped.
- Selection: the eligible branch with minimum age wins. On an age tie, the lowest index wins.
- `OUT_branch` carries all fields of the winner, with `taken=1`. With no winner it is all-zero.
- Accept: a winner is accepted every cycle one exists. On accept:
  - `flushSqN <= winner.sqN`.
  - `OUT_mispredCount` increments, holding at 2^CNT_W-1.
- FSM states are IDLE, FLUSH and DRAIN. An accept overrides every other transition.
  - Any state, accept: go to FLUSH if `curSqN != nextSqN`, else IDLE.
  - FLUSH, no accept: go to DRAIN if `curSqN == nextSqN`, else stay in FLUSH.
  - DRAIN, no accept: go to IDLE unconditionally. DRAIN is a one-cycle guard.
- `OUT_mispredFlush = (state != IDLE)`, driven from a register.
- Reset values:
  - State is IDLE and `flushSqN` is 0.
  - `OUT_mispredFlush` is 0 and `OUT_mispredCount` is 0.
  - `OUT_branch` is all-zero.
- Reset may assert at any time and immediately discards any in-progress window.

## Timing
- Default build: `OUT_branch` is combinational from the inputs and the current state, with zero latency.
- `OUT_mispredFlush` asserts in the cycle after the accept.
- Sequence of a drained window:
  - Accept at cycle t, with a non-empty window.
  - Flush asserted from t+1.
  - `curSqN == nextSqN` first seen at cycle d gives DRAIN at d+1.
  - Flush deasserts at d+2.
- An older branch arriving during FLUSH or DRAIN is accepted immediately and restarts the window.
- Wrap-around: age arithmetic stays correct across the 2^SQN_W boundary, provided all live sqNs lie in `[curSqN, nextSqN)`.

## Configuration
- `BRANCH_SEL_OUT_REG_EN` defined:
  - `OUT_branch` is registered, so a winner at cycle t is visible at t+1 for exactly one cycle.
  - The FSM and counter update on the same edge, so `OUT_mispredFlush` and `OUT_branch.taken` rise together.
  - The registered output resets to zero.
- Macro undefined: the combinational behaviour described above.

## Structure
- Shared package holds:
  - the `BranchProv` typedef;
  - the FSM state enum `MispredState_t`;
  - the `SQN_W` default constant.
- Sub-module `age_min_tree`: a log2(NUM_BRANCHES) comparison tree.
  - Inputs: valid/age pairs.
  - Outputs: winner index and winner valid.
  - Ties resolve to the lower index.

## Test plan
- Reset, then curSqN=5, nextSqN=12, branches 1 (sqN 9) and 3 (sqN 7) taken → OUT_branch.sqN=7; flush asserted next cycle; count=1.
- Wrap: curSqN=60, live branch sqNs 62 and 2 → 62 selected. Plain signed pairwise compare gives the same here; the stronger check is sqNs 61 and 29 with curSqN=60, where 61 must win.
- During FLUSH with flushSqN=7: sqN 7 and sqN 10 are ignored, no count change; sqN 6 is accepted and flushSqN becomes 6.
- Drain: with curSqN==nextSqN from cycle d, DRAIN at d+1 and flush low at d+2. The same again, but with a branch arriving during DRAIN: the branch is accepted and the FSM returns to FLUSH.
- Equal sqN 20 on channels 0 and 2, with differing dstPC → channel 0's dstPC is output. With the macro enabled, it appears one cycle later, coincident with the flush rising.
- Reset asserted mid-FLUSH → flush, state, count and output drop to zero asynchronously. After release, the first branch is accepted.
